uart_rx_sipo: RTL and testbench
===============================

# uart_rx_sipo

Serial-in/parallel-out UART receiver: the far end of the link driven by the team's PISO transmitter. Samples the serial line once per bit-rate clock, reassembles start + FIFO_WIDTH data bits (MSB first) + parity + stop frames into bytes, and checks parity, framing and break. Presents each byte through a valid/ack holding register to the downstream RX FIFO, with overrun detection.

## Interface
- FIFO_WIDTH, 8: data bits per frame.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity.
- SYNC_STAGES, 2: synchronizer depth on `rx`, legal values 2 or more.
- Tx_clk  in  1  bit-rate clock, rising edge. One frame bit per cycle.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  serial line, idle high, asynchronous to Tx_clk.
- rx_ack  in  1  consumer accepted `dout`; clears `rx_valid`.
- dout  out  FIFO_WIDTH  last received byte; reset value 0.
- rx_valid  out  1  `dout` holds an unread byte; reset value 0.
- rx_done  out  1  one-cycle pulse per completed frame, including errored frames; reset value 0.
- parity_err  out  1  parity status of the latest frame; updated with `rx_done`; reset value 0.
- frame_err  out  1  stop bit of the latest frame was 0; updated with `rx_done`; reset value 0.
- break_det  out  1  latest frame was all zeros with stop bit 0; held until `rx` returns high; reset value 0.
- overrun  out  1  sticky; set when a frame completes while `rx_valid` is still 1; cleared by `rx_ack`; reset value 0.
- busy  out  1  FSM is not in IDLE; reset value 0.

## Operation
- `rx` passes through SYNC_STAGES flops, reset to 1. The synchronized value is `rx_s`.
- FSM states, in package enum order: IDLE, DATA, PARITY, STOP, BREAK.
- **IDLE**
  - `rx_s == 0`: the start bit is consumed. Clear the bit counter and go to DATA.
  - Otherwise stay in IDLE.
- **DATA**
  - Each cycle: shift register <= {sr[FIFO_WIDTH-2:0], rx_s}, and the counter increments.
  - After FIFO_WIDTH bits, go to PARITY.
- **PARITY**: capture `rx_s` as the parity bit, then go to STOP.
- **STOP**: sample `rx_s`.
  - `rx_s == 1`: go to IDLE.
  - `rx_s == 0`: set `frame_err` and go to BREAK.
  - If `rx_s == 0` and the data bits are all zero, also set `break_det`.
- **BREAK**: stay until `rx_s == 1`, then go to IDLE and clear `break_det`.
- Frame completion, on the STOP-exit edge:
  - `dout` <= shift register.
  - `rx_valid` <= 1.
  - `rx_done` pulses.
  - `parity_err` <= parity bit != (^data ^ PARITY_ODD).
  - If `rx_valid` was already 1 and `rx_ack` is not asserted on the same edge, `overrun` <= 1 and `dout` is overwritten.
- Errored frames still load `dout` and set `rx_valid`. The consumer qualifies the byte with the error flags.
- Simultaneous `rx_ack` and frame completion: new data is loaded, `rx_valid` stays 1, and no overrun.
- `rx_ack` while `rx_valid == 0`: no effect.
- Back-to-back frames: a start bit immediately after a valid stop bit is accepted. STOP→IDLE, then IDLE sees the start on the next cycle, with no gap.
- Asserting `rst` mid-frame returns the FSM to IDLE, clears all outputs and the synchronizer, and discards the partial frame.

## Timing
- Start bit first captured by sync flop 1 at edge t:
  - FSM enters DATA at edge t+SYNC_STAGES.
  - `rx_done` is high for the single cycle after edge t+SYNC_STAGES+FIFO_WIDTH+2. Defaults give t+12.
- Latency from start bit to byte = SYNC_STAGES + FIFO_WIDTH + 2 cycles.
- Minimum frame period is FIFO_WIDTH+3 cycles, which is line rate.
- All outputs are registered. There is no combinational path from `rx` or `rx_ack` to any output.
- The bit counter is $clog2(FIFO_WIDTH+1) bits wide and never wraps inside a frame.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum (IDLE, DATA, PARITY, STOP, BREAK).
  - Parity-mode constants PARITY_EVEN / PARITY_ODD, shared with the transmitter's parity generator.
- Sub-module `uart_sync`: parameterized N-flop synchronizer with asynchronous reset to a parameterized value (1 here). It is reusable for other asynchronous inputs.

## Test plan
- **Basic frame**: after reset, drive 0xA5 MSB first with parity 0 and stop 1.
  - `rx_done` pulses at t+12.
  - `dout` = 0xA5, `rx_valid` = 1, all error flags 0.
- **Back-to-back frames**: drive 0x3C then 0xC3 with no idle gap, even parity, acking each byte.
  - Two `rx_done` pulses 11 cycles apart, `dout` = 0x3C then 0xC3, no errors.
- **Parity error**: drive 0x01 with parity bit 0.
  - `dout` = 0x01, `parity_err` = 1.
  - Rerun with PARITY_ODD = 1: `parity_err` = 0.
- **Framing error and break**:
  - 0x55 with stop bit 0: `frame_err` = 1, `break_det` = 0, FSM holds in BREAK until `rx` = 1.
  - `rx` held low for 20 cycles: `frame_err` = 1 and `break_det` = 1, and no second frame is decoded until `rx` goes high.
- **Overrun**: receive 0x11, then 0x22 without `rx_ack`.
  - `overrun` = 1 and `dout` = 0x22.
  - `rx_ack` clears `rx_valid` and `overrun`.
  - Ack coincident with the second frame's completion: no overrun.
- **Reset mid-frame**: assert `rst` during data bit 4.
  - All outputs return to 0 and `busy` = 0.
  - The next clean frame 0x7E decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and parity-mode constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Parity mode selects, also used by the transmitter's parity generator
  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sipo_if.sv
// rtl/uart_rx_sipo_if.sv - received-byte holding register and frame status bus
interface uart_rx_sipo_if #(
  parameter int FIFO_WIDTH = 8
);
  logic [FIFO_WIDTH-1:0] dout;
  logic                  rx_valid;
  logic                  rx_ack;
  logic                  rx_done;
  logic                  parity_err;
  logic                  frame_err;
  logic                  break_det;
  logic                  overrun;

  modport master (
    output dout, rx_valid, rx_done, parity_err, frame_err, break_det, overrun,
    input  rx_ack
  );

  modport slave (
    input  dout, rx_valid, rx_done, parity_err, frame_err, break_det, overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - N-flop synchronizer with asynchronous reset to a set value
module uart_sync #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx_sipo.sv
// rtl/uart_rx_sipo.sv - UART receiver: start + MSB-first data + parity + stop into bytes
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int FIFO_WIDTH  = 8,
  parameter bit PARITY_ODD  = uart_pkg::PARITY_EVEN,
  parameter int SYNC_STAGES = 2
) (
  input  logic           Tx_clk,
  input  logic           rst,
  input  logic           rx,
  output logic           busy,
  uart_rx_sipo_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_WIDTH + 1);

  logic rx_s;

  uart_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i(Tx_clk),
    .rst_i(rst),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FIFO_WIDTH-1:0] sr_q, sr_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  par_q, par_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  brk_q, brk_d;
  logic                  ovr_q, ovr_d;
  logic                  complete;

  always_ff @(posedge Tx_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dout_q  <= '0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    par_d    = par_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    brk_d    = brk_q;
    complete = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        sr_d  = {sr_q[FIFO_WIDTH-2:0], rx_s};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FIFO_WIDTH - 1)) begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        par_d   = rx_s;
        state_d = STOP;
      end
      STOP: begin
        complete = 1'b1;
        ferr_d   = !rx_s;
        perr_d   = par_q != (^sr_q ^ PARITY_ODD);
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
          brk_d   = (sr_q == '0);
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
          brk_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An ack on the completion edge consumes the old byte, so the new one is not an overrun
  always_comb begin
    done_d  = complete;
    dout_d  = complete ? sr_q : dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (bus.rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (complete) begin
      valid_d = 1'b1;
      if (valid_q && !bus.rx_ack) begin
        ovr_d = 1'b1;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.rx_valid   = valid_q;
  assign bus.rx_done    = done_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.break_det  = brk_q;
  assign bus.overrun    = ovr_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_sipo.sv
// tb/tb_uart_rx_sipo.sv - directed bench for uart_rx_sipo (even and odd parity instances)
module tb_uart_rx_sipo;
  logic Tx_clk = 1'b0;
  logic rst;
  logic rx;
  logic rx_ack;
  logic busy0, busy1;
  int   cyc = 0;

  always #5 Tx_clk = ~Tx_clk;
  always @(posedge Tx_clk) cyc <= cyc + 1;

  uart_rx_sipo_if #(.FIFO_WIDTH(8)) bus0 ();
  uart_rx_sipo_if #(.FIFO_WIDTH(8)) bus1 ();
  assign bus0.rx_ack = rx_ack;
  assign bus1.rx_ack = rx_ack;

  uart_rx_sipo #(.FIFO_WIDTH(8), .PARITY_ODD(1'b0), .SYNC_STAGES(2)) dut (
    .Tx_clk(Tx_clk), .rst(rst), .rx(rx), .busy(busy0), .bus(bus0)
  );

  uart_rx_sipo #(.FIFO_WIDTH(8), .PARITY_ODD(1'b1), .SYNC_STAGES(2)) dut_odd (
    .Tx_clk(Tx_clk), .rst(rst), .rx(rx), .busy(busy1), .bus(bus1)
  );

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       pe, fe, bd, ov, v, pe_odd;
  } rec_t;

  rec_t recs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   auto_ack = 1'b0;
  int   t_start;
  rec_t r0, r1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bit period: record any rx_done seen at this negedge, then drive the next line value
  task automatic tick(input logic b, input logic a);
    logic done_now;
    @(negedge Tx_clk);
    done_now = bus0.rx_done;
    if (done_now) begin
      recs.push_back('{cyc, bus0.dout, bus0.parity_err, bus0.frame_err,
                       bus0.break_det, bus0.overrun, bus0.rx_valid, bus1.parity_err});
    end
    rx     = b;
    rx_ack = a | (auto_ack & done_now);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    tick(1'b0, 1'b0);
    t_start = cyc + 1;
    for (int i = 7; i >= 0; i--) tick(d[i], 1'b0);
    tick(p, 1'b0);
    tick(s, 1'b0);
  endtask

  task automatic ack_byte();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
  endtask

  function automatic rec_t get_rec(input int i);
    rec_t r;
    if (i < recs.size()) return recs[i];
    r.cyc = -1; r.d = 8'hxx;
    r.pe = 1'bx; r.fe = 1'bx; r.bd = 1'bx; r.ov = 1'bx; r.v = 1'bx; r.pe_odd = 1'bx;
    return r;
  endfunction

  initial begin
    rst = 1'b1; rx = 1'b1; rx_ack = 1'b0;
    repeat (3) @(negedge Tx_clk);
    rst = 1'b0;
    idle(2);
    check("rst_dout", bus0.dout, 8'h00);
    check("rst_valid", bus0.rx_valid, 0);
    check("rst_done", bus0.rx_done, 0);
    check("rst_flags", {bus0.parity_err, bus0.frame_err, bus0.break_det, bus0.overrun}, 0);
    check("rst_busy", busy0, 0);

    // Basic frame 0xA5, even parity bit 0
    recs.delete();
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(4);
    r0 = get_rec(0);
    check("basic_count", recs.size(), 1);
    check("basic_latency", r0.cyc - t_start, 12);
    check("basic_dout", r0.d, 8'hA5);
    check("basic_valid", r0.v, 1);
    check("basic_pe", r0.pe, 0);
    check("basic_fe", r0.fe, 0);
    check("basic_bd", r0.bd, 0);
    check("basic_ov", r0.ov, 0);
    check("basic_pe_odd", r0.pe_odd, 1);
    ack_byte();
    check("basic_ack_valid", bus0.rx_valid, 0);
    check("basic_busy", busy0, 0);

    // Back-to-back 0x3C, 0xC3 with auto-ack
    recs.delete();
    auto_ack = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1);
    idle(4);
    auto_ack = 1'b0;
    r0 = get_rec(0); r1 = get_rec(1);
    check("b2b_count", recs.size(), 2);
    check("b2b_spacing", r1.cyc - r0.cyc, 11);
    check("b2b_dout0", r0.d, 8'h3C);
    check("b2b_dout1", r1.d, 8'hC3);
    check("b2b_err0", {r0.pe, r0.fe, r0.bd, r0.ov}, 0);
    check("b2b_err1", {r1.pe, r1.fe, r1.bd, r1.ov}, 0);
    check("b2b_valid_after", bus0.rx_valid, 0);

    // Parity error: 0x01 with parity bit 0
    recs.delete();
    send_frame(8'h01, 1'b0, 1'b1);
    idle(4);
    r0 = get_rec(0);
    check("par_dout", r0.d, 8'h01);
    check("par_pe_even", r0.pe, 1);
    check("par_pe_odd", r0.pe_odd, 0);
    ack_byte();

    // Framing error 0x55 with stop bit 0, then line held low briefly
    recs.delete();
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (5) tick(1'b0, 1'b0);
    r0 = get_rec(0);
    check("frm_count", recs.size(), 1);
    check("frm_dout", r0.d, 8'h55);
    check("frm_fe", r0.fe, 1);
    check("frm_bd", r0.bd, 0);
    check("frm_hold_busy", busy0, 1);
    idle(4);
    check("frm_release_busy", busy0, 0);
    ack_byte();

    // Break: line low for 20 bit times
    recs.delete();
    repeat (20) tick(1'b0, 1'b0);
    check("brk_live_bd", bus0.break_det, 1);
    check("brk_live_busy", busy0, 1);
    idle(4);
    r0 = get_rec(0);
    check("brk_count", recs.size(), 1);
    check("brk_dout", r0.d, 8'h00);
    check("brk_fe", r0.fe, 1);
    check("brk_bd", r0.bd, 1);
    check("brk_clear_bd", bus0.break_det, 0);
    check("brk_clear_busy", busy0, 0);
    ack_byte();

    // Overrun: 0x11 then 0x22 with no ack
    recs.delete();
    send_frame(8'h11, 1'b0, 1'b1);
    idle(2);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(4);
    r0 = get_rec(0); r1 = get_rec(1);
    check("ovr_count", recs.size(), 2);
    check("ovr_first_ov", r0.ov, 0);
    check("ovr_second_ov", r1.ov, 1);
    check("ovr_dout", r1.d, 8'h22);
    ack_byte();
    check("ovr_ack_valid", bus0.rx_valid, 0);
    check("ovr_ack_ov", bus0.overrun, 0);

    // Ack lands on the second frame's completion edge
    recs.delete();
    send_frame(8'h11, 1'b0, 1'b1);
    idle(2);
    send_frame(8'h22, 1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    r1 = get_rec(1);
    check("coin_ov", r1.ov, 0);
    check("coin_valid", r1.v, 1);
    check("coin_dout", r1.d, 8'h22);

    // Reset during data bit 4, then a clean 0x7E
    recs.delete();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("mid_busy", busy0, 1);
    rst = 1'b1;
    idle(2);
    check("mid_rst_dout", bus0.dout, 8'h00);
    check("mid_rst_flags", {bus0.rx_valid, bus0.rx_done, bus0.parity_err, bus0.frame_err,
                            bus0.break_det, bus0.overrun, busy0}, 0);
    rst = 1'b0;
    idle(3);
    send_frame(8'h7E, 1'b0, 1'b1);
    idle(4);
    r0 = get_rec(0);
    check("post_count", recs.size(), 1);
    check("post_latency", r0.cyc - t_start, 12);
    check("post_dout", r0.d, 8'h7E);
    check("post_err", {r0.pe, r0.fe, r0.bd, r0.ov}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
